// File: rtl/fetch_redirect_ctrl.sv
// Fetch1 PC sequencer: selects between PC+8 and a redirect target (ex > id), boots from RESET_VECTOR.
// Latency: pc_we_o/pc_sel_o/target_o/flush_o are combinational same-cycle; slot0_kill_o is registered (one cycle later).
// Backpressure: stall_i holds the PC unless a redirect is taken; redirects always write the PC.
// Optional macro REDIRECT_STATS_EN adds per-source accepted-redirect counters.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_target_i,
    input  logic        id_redirect_i,
    input  logic [31:0] id_target_i,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic [31:0] target_o,
    output logic        flush_o,
`ifdef REDIRECT_STATS_EN
    output logic [31:0] ex_redir_cnt_o,
    output logic [31:0] id_redir_cnt_o,
`endif
    output logic        slot0_kill_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Count loaded on a redirect; the decode shadow lasts while it is non-zero.
    localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        kill_q;

    logic        boot_take;
    logic        ex_take;
    logic        id_take;
    logic        redir_take;
    logic        seq_adv;
    logic [31:0] redir_tgt;
    logic [31:0] target_d;

    // Low target bits never reach the PC (8-byte fetch groups; bit 2 only feeds slot kill).
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^{ex_target_i[1:0], id_target_i[1:0]};

    // Redirect arbitration: BOOT forces the reset vector, execute beats decode, decode is masked in FLUSH.
    always_comb begin
        boot_take = 1'b0;
        ex_take   = 1'b0;
        id_take   = 1'b0;
        redir_tgt = 32'h0000_0000;
        unique case (state_q)
            ST_BOOT: begin
                boot_take = 1'b1;
                redir_tgt = RESET_VECTOR;
            end
            ST_RUN: begin
                if (ex_redirect_i) begin
                    ex_take   = 1'b1;
                    redir_tgt = ex_target_i;
                end else if (id_redirect_i) begin
                    id_take   = 1'b1;
                    redir_tgt = id_target_i;
                end
            end
            ST_FLUSH: begin
                if (ex_redirect_i) begin
                    ex_take   = 1'b1;
                    redir_tgt = ex_target_i;
                end
            end
            default: begin
                boot_take = 1'b0;
            end
        endcase
        redir_take = boot_take | ex_take | id_take;
        seq_adv    = ~redir_take & ~stall_i;
        target_d   = {redir_tgt[31:3], 3'b000};
    end

    // Fetch1 controls; everything is held low while reset is asserted.
    always_comb begin
        pc_we_o      = 1'b0;
        pc_sel_o     = 1'b0;
        target_o     = 32'h0000_0000;
        flush_o      = 1'b0;
        slot0_kill_o = 1'b0;
        if (!reset_i) begin
            pc_we_o      = redir_take | ~stall_i;
            pc_sel_o     = redir_take;
            target_o     = redir_take ? target_d : 32'h0000_0000;
            flush_o      = redir_take;
            slot0_kill_o = kill_q;
        end
    end

    // Controller FSM: boot redirect, run, and post-redirect decode shadow; also tracks slot-0 kill.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_BOOT;
            cnt_q   <= 4'd0;
            kill_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                    cnt_q   <= 4'd0;
                    kill_q  <= RESET_VECTOR[2];
                end
                ST_RUN, ST_FLUSH: begin
                    if (ex_take || id_take) begin
                        cnt_q   <= CNT_RELOAD;
                        state_q <= (CNT_RELOAD != 4'd0) ? ST_FLUSH : ST_RUN;
                        kill_q  <= redir_tgt[2];
                    end else begin
                        // A sequential PC write moves past the partially valid group.
                        if (seq_adv) begin
                            kill_q <= 1'b0;
                        end
                        if (state_q == ST_FLUSH) begin
                            if (cnt_q <= 4'd1) begin
                                cnt_q   <= 4'd0;
                                state_q <= ST_RUN;
                            end else begin
                                cnt_q <= cnt_q - 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                    cnt_q   <= 4'd0;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REDIRECT_STATS_EN
    logic [31:0] ex_cnt_q;
    logic [31:0] id_cnt_q;

    // Accepted-redirect counters per source; the boot redirect is not counted, counters wrap.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ex_cnt_q <= 32'd0;
            id_cnt_q <= 32'd0;
        end else begin
            if (ex_take) begin
                ex_cnt_q <= ex_cnt_q + 32'd1;
            end
            if (id_take) begin
                id_cnt_q <= id_cnt_q + 32'd1;
            end
        end
    end

    assign ex_redir_cnt_o = ex_cnt_q;
    assign id_redir_cnt_o = id_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with RESET_VECTOR=0x104 (aligned 0x100, bit 2 set) and FLUSH_CYCLES=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every comparison goes through chk; one summary line at the end.
module tb_fetch_redirect_ctrl;

    logic        clock_i;
    logic        reset_i;
    logic        stall_i;
    logic        ex_redirect_i;
    logic [31:0] ex_target_i;
    logic        id_redirect_i;
    logic [31:0] id_target_i;
    logic        pc_we_o;
    logic        pc_sel_o;
    logic [31:0] target_o;
    logic        flush_o;
    logic        slot0_kill_o;
`ifdef REDIRECT_STATS_EN
    logic [31:0] ex_redir_cnt_o;
    logic [31:0] id_redir_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_redirect_ctrl #(
        .RESET_VECTOR (32'h0000_0104),
        .FLUSH_CYCLES (2)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .ex_redirect_i (ex_redirect_i),
        .ex_target_i   (ex_target_i),
        .id_redirect_i (id_redirect_i),
        .id_target_i   (id_target_i),
        .pc_we_o       (pc_we_o),
        .pc_sel_o      (pc_sel_o),
        .target_o      (target_o),
        .flush_o       (flush_o),
`ifdef REDIRECT_STATS_EN
        .ex_redir_cnt_o(ex_redir_cnt_o),
        .id_redir_cnt_o(id_redir_cnt_o),
`endif
        .slot0_kill_o  (slot0_kill_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic we, input logic sel,
                            input logic [31:0] tgt, input logic fl, input logic kill);
        @(negedge clock_i);
        chk({tag, ".we"},    {31'd0, pc_we_o},      {31'd0, we});
        chk({tag, ".sel"},   {31'd0, pc_sel_o},     {31'd0, sel});
        chk({tag, ".tgt"},   target_o,              tgt);
        chk({tag, ".flush"}, {31'd0, flush_o},      {31'd0, fl});
        chk({tag, ".kill"},  {31'd0, slot0_kill_o}, {31'd0, kill});
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        reset_i       = 1'b1;
        stall_i       = 1'b0;
        ex_redirect_i = 1'b1;
        ex_target_i   = 32'h0000_2004;
        id_redirect_i = 1'b0;
        id_target_i   = 32'h0000_0000;

        // Reset with a redirect request present: everything must stay low.
        @(posedge clock_i);
        chk_outs("rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Boot cycle ignores stall.
        step();
        reset_i       = 1'b0;
        ex_redirect_i = 1'b0;
        stall_i       = 1'b1;
        chk_outs("boot", 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);

        step();
        stall_i = 1'b0;
        chk_outs("run0", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        step();
        chk_outs("run1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Execute redirect to a bit-2 target.
        step();
        ex_redirect_i = 1'b1;
        ex_target_i   = 32'h0000_2004;
        chk_outs("ex", 1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b0);

        // Decode redirect one cycle later lands in the shadow.
        step();
        ex_redirect_i = 1'b0;
        id_redirect_i = 1'b1;
        id_target_i   = 32'h0000_3000;
        chk_outs("idshadow", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // Two cycles later it is accepted.
        step();
        chk_outs("idok", 1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b0);

        step();
        id_redirect_i = 1'b0;
        chk_outs("flsh", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Both sources together in RUN: execute wins; low target bits dropped.
        step();
        ex_redirect_i = 1'b1;
        ex_target_i   = 32'h0000_0047;
        id_redirect_i = 1'b1;
        id_target_i   = 32'h0000_0080;
        chk_outs("both", 1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0);

        // Stall in the shadow cycle, then five stalled RUN cycles; kill held.
        step();
        ex_redirect_i = 1'b0;
        id_redirect_i = 1'b0;
        stall_i       = 1'b1;
`ifdef REDIRECT_STATS_EN
        chk("cnt_ex_a", ex_redir_cnt_o, 32'd2);
        chk("cnt_id_a", id_redir_cnt_o, 32'd1);
`endif
        chk_outs("stlf", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            step();
            chk_outs($sformatf("stl%0d", i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end

        // Redirect overrides stall.
        step();
        ex_redirect_i = 1'b1;
        ex_target_i   = 32'h0000_0504;
        chk_outs("exstl", 1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b1);

        // In FLUSH with kill pending, assert reset.
        step();
        ex_redirect_i = 1'b0;
        stall_i       = 1'b0;
        chk("kill_pre", {31'd0, slot0_kill_o}, 32'd1);
        reset_i       = 1'b1;
        ex_redirect_i = 1'b1;
        chk_outs("rstfl", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        step();
        reset_i       = 1'b0;
        ex_redirect_i = 1'b0;
`ifdef REDIRECT_STATS_EN
        chk("cnt_ex_r", ex_redir_cnt_o, 32'd0);
        chk("cnt_id_r", id_redir_cnt_o, 32'd0);
`endif
        chk_outs("boot2", 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);

        step();
        chk_outs("run2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        step();
        chk_outs("run3", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequences the dual-issue fetch PC register; it is the controller for the fetch1 stage.
- Selects, each cycle, between sequential PC+8 and a redirect target.
- Arbitrates redirect requests from execute (branch/jump resolve) and decode (early jump).
- Drives pc_we/pc_sel into fetch1 and emits flush and slot-kill controls to the fetch buffer.
- Runs a small FSM that boots from the reset vector and masks wrong-path decode redirects after a flush.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
FLUSH_CYCLES, 2, cycles after a redirect during which id_redirect_i is ignored (PC→decode depth); legal range 1–15.

Ports:
clock_i  in  1  core clock, all state on rising edge
reset_i  in  1  synchronous, active-high reset
stall_i  in  1  backend cannot accept a fetch group; hold PC
ex_redirect_i  in  1  execute redirect request (highest priority)
ex_target_i  in  32  execute redirect target
id_redirect_i  in  1  decode redirect request
id_target_i  in  32  decode redirect target
pc_we_o  out  1  PC write enable to fetch1
pc_sel_o  out  1  0 = PC+8, 1 = target_o
target_o  out  32  8-byte-aligned redirect address {tgt[31:3],3'b000}
flush_o  out  1  one-cycle pulse: kill all in-flight fetch groups
slot0_kill_o  out  1  current PC group's slot 0 (lower word) is invalid

Behaviour:
- Reset (reset_i=1 at an edge):
  - Next state BOOT; flush counter = 0; kill_pending = 0.
  - During reset, outputs are pc_we_o=0, pc_sel_o=0, target_o=0, flush_o=0, slot0_kill_o=0.
- FSM states are BOOT, RUN and FLUSH. pc_we_o, pc_sel_o, target_o and flush_o are combinational from state and inputs. PC is updated by fetch1 at the same edge, so the target is visible on pc_o one cycle after the request.
- BOOT:
  - Outputs: pc_we_o=1, pc_sel_o=1, target_o=RESET_VECTOR aligned, flush_o=1.
  - stall_i and all redirects are ignored.
  - kill_pending ← RESET_VECTOR[2]. Next state is RUN.
- RUN, priority ex > id > stall > sequential:
  - ex_redirect_i: pc_we_o=1, pc_sel_o=1, target from ex_target_i, flush_o=1. Load count=FLUSH_CYCLES−1. Next state is FLUSH if count>0, else RUN.
  - id_redirect_i (ex idle): identical behaviour, using id_target_i.
  - stall_i: pc_we_o=0.
  - Otherwise: pc_we_o=1, pc_sel_o=0.
- FLUSH:
  - ex_redirect_i is accepted exactly as in RUN and reloads the count.
  - id_redirect_i is ignored (wrong-path shadow).
  - Otherwise stall/sequential as in RUN.
  - Count decrements each cycle; at count==0 with no new redirect, next state is RUN.
- Redirects override stall_i: pc_we_o=1 even while stall_i=1.
- kill_pending:
  - Set to tgt[2] on any accepted redirect.
  - Cleared on the next pc_we_o=1 with pc_sel_o=0.
  - Held through stalls.
  - slot0_kill_o = kill_pending.
- Target bits [1:0] are ignored (treated as 0); no misalignment trap is raised here.
- Simultaneous ex and id redirect: ex wins and id is dropped, not queued.
- When no redirect is accepted, target_o is don't-care but driven to 0.

Optional Feature:
Macro REDIRECT_STATS_EN.
- Defined: adds outputs ex_redir_cnt_o[31:0] and id_redir_cnt_o[31:0].
  - Each counts accepted redirects of its source; the BOOT redirect is not counted.
  - Ignored id redirects are not counted.
  - Counters wrap at 2^32 and clear on reset_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_VECTOR=0x100, release → cycle 1: pc_we=1, sel=1, target=0x100, flush=1, slot0_kill=0; next cycles sel=0, we=1.
- RUN, ex_redirect=1, ex_target=0x2004 → same cycle: we=1, sel=1, target=0x2000, flush=1; next cycle slot0_kill=1; it clears after the first sequential pc_we.
- Both redirects asserted together, ex_target=0x40, id_target=0x80 → target=0x40; with stats enabled ex_cnt=1, id_cnt=0.
- id_redirect asserted 1 cycle after an ex redirect (FLUSH_CYCLES=2) → ignored: sel=0, flush=0; id_redirect asserted 2 cycles after → accepted.
- stall_i held 5 cycles in RUN → pc_we=0 throughout; an ex_redirect during the stall → we=1, sel=1 that cycle.
- reset_i asserted while in FLUSH with kill_pending=1 → all outputs 0 during reset, BOOT sequence repeats, kill_pending=RESET_VECTOR[2].
